// File: rtl/axis_tx_frame_buffer_pkg.sv
// Shared types and defaults for the store-and-forward TX frame buffer.
// Holds write-FSM state codes, the default frame limit and a length helper.
package axis_tx_frame_buffer_pkg;

  typedef enum logic [1:0] {
    WR_IDLE  = 2'd0,
    WR_STORE = 2'd1,
    WR_DROP  = 2'd2
  } wr_state_t;

  localparam int DATA_WIDTH_DEF    = 8;
  localparam int MAX_FRAME_LEN_DEF = 1522;
  localparam int LEN_W             = 16;

  function automatic logic [LEN_W-1:0] sat_inc(
    input logic [LEN_W-1:0] v
  );
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/axis_tx_frame_buffer_if.sv
// AXI4-Stream byte channel with sideband bad-frame flag.
// master drives data/valid/last/user, slave drives ready.
interface axis_tx_frame_buffer_if
  import axis_tx_frame_buffer_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
);

  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;
  logic                  tuser;

  modport master (
    output tdata,
    output tvalid,
    output tlast,
    output tuser,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    input  tlast,
    input  tuser,
    output tready
  );

endinterface

// File: rtl/axis_tx_frame_buffer_ram.sv
// Simple dual-port frame RAM: synchronous write, registered read.
// The array carries no reset; readers only consume committed words.
module axis_tx_frame_buffer_ram
  import axis_tx_frame_buffer_pkg::*;
#(
  parameter int WIDTH = DATA_WIDTH_DEF + 2,
  parameter int DEPTH = 4096,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/axis_tx_frame_buffer.sv
// Store-and-forward frame FIFO ahead of the GMII transmitter.
// Only whole frames are released, so the output never underflows mid-frame.
module axis_tx_frame_buffer
  import axis_tx_frame_buffer_pkg::*;
#(
  parameter int DATA_WIDTH       = DATA_WIDTH_DEF,
  parameter int DEPTH            = 4096,
  parameter int MAX_FRAME_LENGTH = MAX_FRAME_LEN_DEF,
  parameter bit DROP_BAD_FRAME   = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  axis_tx_frame_buffer_if.slave  s_axis,
  axis_tx_frame_buffer_if.master m_axis,
  output logic status_overflow,
  output logic status_bad_frame,
  output logic status_good_frame
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int WW = DATA_WIDTH + 2;

  if (DATA_WIDTH != 8) begin : g_chk_width
    $error("axis_tx_frame_buffer: DATA_WIDTH must be 8");
  end

  if ((1 << AW) != DEPTH || DEPTH < MAX_FRAME_LENGTH) begin : g_chk_depth
    $error("axis_tx_frame_buffer: bad DEPTH");
  end

  wr_state_t      wr_state;
  logic [PW-1:0]  wr_ptr_cur;
  logic [PW-1:0]  wr_ptr_commit;
  logic [PW-1:0]  rd_ptr;
  logic [LEN_W-1:0] len_cnt;
  logic [LEN_W-1:0] cur_len;
  logic           in_rdy;
  logic           full;
  logic           empty;
  logic           accept;
  logic           over;
  logic           wr_en;
  logic           rd_en;
  logic           fire;
  logic [1:0]     slots;
  logic [WW-1:0]  wr_word;
  logic [WW-1:0]  rd_word;
  logic           ram_vld;
  logic           out_vld;
  logic           skid_vld;
  logic [WW-1:0]  out_word;
  logic [WW-1:0]  skid_word;

  assign full    = (wr_ptr_cur - rd_ptr) == PW'(DEPTH);
  assign empty   = rd_ptr == wr_ptr_commit;
  assign accept  = s_axis.tvalid & in_rdy;
  assign cur_len = (wr_state == WR_IDLE) ? '0 : len_cnt;
  assign over    = full | (cur_len == LEN_W'(MAX_FRAME_LENGTH));
  assign wr_en   = accept & (wr_state != WR_DROP) & ~over;
  assign wr_word = {s_axis.tuser & s_axis.tlast,
                    s_axis.tlast, s_axis.tdata};

  assign s_axis.tready = in_rdy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_rdy            <= 1'b0;
      wr_state          <= WR_IDLE;
      wr_ptr_cur        <= '0;
      wr_ptr_commit     <= '0;
      len_cnt           <= '0;
      status_overflow   <= 1'b0;
      status_bad_frame  <= 1'b0;
      status_good_frame <= 1'b0;
    end else begin
      in_rdy            <= 1'b1;
      status_overflow   <= 1'b0;
      status_bad_frame  <= 1'b0;
      status_good_frame <= 1'b0;
      if (accept) begin
        if (wr_state == WR_DROP) begin
          if (s_axis.tlast) begin
            wr_state <= WR_IDLE;
          end
        end else if (over) begin
          // Abandon the partial frame; skip its tail unless this was the end.
          wr_ptr_cur      <= wr_ptr_commit;
          status_overflow <= 1'b1;
          wr_state        <= s_axis.tlast ? WR_IDLE : WR_DROP;
        end else begin
          wr_ptr_cur <= wr_ptr_cur + 1'b1;
          len_cnt    <= sat_inc(cur_len);
          wr_state   <= WR_STORE;
          if (s_axis.tlast) begin
            wr_state <= WR_IDLE;
            if (s_axis.tuser && DROP_BAD_FRAME) begin
              wr_ptr_cur       <= wr_ptr_commit;
              status_bad_frame <= 1'b1;
            end else begin
              wr_ptr_commit     <= wr_ptr_cur + 1'b1;
              status_bad_frame  <= s_axis.tuser;
              status_good_frame <= ~s_axis.tuser;
            end
          end
        end
      end
    end
  end

  axis_tx_frame_buffer_ram #(
    .WIDTH (WW),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr_cur[AW-1:0]),
    .wdata (wr_word),
    .re    (rd_en),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (rd_word)
  );

  // Output reg + skid hold two words; a read is issued only if its
  // word is guaranteed a slot when it lands one cycle later.
  assign fire  = out_vld & m_axis.tready;
  assign slots = {1'b0, out_vld} + {1'b0, skid_vld} + {1'b0, ram_vld};
  assign rd_en = ~empty &
                 ((slots < 2'd2) | ((slots == 2'd2) & fire));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr    <= '0;
      ram_vld   <= 1'b0;
      out_vld   <= 1'b0;
      skid_vld  <= 1'b0;
      out_word  <= '0;
      skid_word <= '0;
    end else begin
      ram_vld <= rd_en;
      if (rd_en) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (fire) begin
        if (skid_vld) begin
          out_word <= skid_word;
          skid_vld <= ram_vld;
          if (ram_vld) begin
            skid_word <= rd_word;
          end
        end else begin
          out_vld <= ram_vld;
          if (ram_vld) begin
            out_word <= rd_word;
          end
        end
      end else if (!out_vld) begin
        out_vld <= ram_vld;
        if (ram_vld) begin
          out_word <= rd_word;
        end
      end else if (ram_vld) begin
        skid_vld  <= 1'b1;
        skid_word <= rd_word;
      end
    end
  end

  assign m_axis.tvalid = out_vld;
  assign {m_axis.tuser, m_axis.tlast, m_axis.tdata} = out_word;

endmodule

// File: tb/tb_axis_tx_frame_buffer.sv
// Bench for axis_tx_frame_buffer: default instance plus a small,
// bad-frame-forwarding instance; scoreboard checks every output beat.
module tb_axis_tx_frame_buffer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sel = 1'b0;
  logic [7:0] in_data = '0;
  logic in_valid = 1'b0;
  logic in_last = 1'b0;
  logic in_user = 1'b0;
  logic rdy_a = 1'b1;
  logic rdy_b = 1'b1;

  logic ovf_a, bad_a, good_a;
  logic ovf_b, bad_b, good_b;

  int checks = 0;
  int fails = 0;
  int n_out = 0;
  int n_ovf = 0;
  int n_bad = 0;
  int n_good = 0;
  logic in_frame = 1'b0;
  logic [9:0] exp_q[$];
  logic [9:0] exp_w;

  always #5 clk = ~clk;

  axis_tx_frame_buffer_if sa ();
  axis_tx_frame_buffer_if ma ();
  axis_tx_frame_buffer_if sb ();
  axis_tx_frame_buffer_if mb ();

  assign sa.tdata  = in_data;
  assign sa.tvalid = in_valid & ~sel;
  assign sa.tlast  = in_last;
  assign sa.tuser  = in_user;
  assign sb.tdata  = in_data;
  assign sb.tvalid = in_valid & sel;
  assign sb.tlast  = in_last;
  assign sb.tuser  = in_user;
  assign ma.tready = rdy_a;
  assign mb.tready = rdy_b;

  axis_tx_frame_buffer dut_a (
    .clk               (clk),
    .rst_n             (rst_n),
    .s_axis            (sa),
    .m_axis            (ma),
    .status_overflow   (ovf_a),
    .status_bad_frame  (bad_a),
    .status_good_frame (good_a)
  );

  axis_tx_frame_buffer #(
    .DEPTH            (128),
    .MAX_FRAME_LENGTH (128),
    .DROP_BAD_FRAME   (1'b0)
  ) dut_b (
    .clk               (clk),
    .rst_n             (rst_n),
    .s_axis            (sb),
    .m_axis            (mb),
    .status_overflow   (ovf_b),
    .status_bad_frame  (bad_b),
    .status_good_frame (good_b)
  );

  logic mv, mr, ml, mu, st_ovf, st_bad, st_good;
  logic [7:0] md;
  assign mv      = sel ? mb.tvalid : ma.tvalid;
  assign mr      = sel ? rdy_b : rdy_a;
  assign ml      = sel ? mb.tlast : ma.tlast;
  assign mu      = sel ? mb.tuser : ma.tuser;
  assign md      = sel ? mb.tdata : ma.tdata;
  assign st_ovf  = sel ? ovf_b : ovf_a;
  assign st_bad  = sel ? bad_b : bad_a;
  assign st_good = sel ? good_b : good_a;

  // Output monitor: scoreboard pop plus no-gap-within-frame check.
  always @(negedge clk) begin
    if (!rst_n) begin
      in_frame = 1'b0;
    end else begin
      if (st_ovf) n_ovf++;
      if (st_bad) n_bad++;
      if (st_good) n_good++;
      if (in_frame) begin
        checks++;
        if (mv !== 1'b1) begin
          fails++;
          $display("FAIL tvalid_gap: tvalid=%b required 1", mv);
        end
      end
      if (mv === 1'b1 && mr === 1'b1) begin
        n_out++;
        checks++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_beat: got %h required none",
                   {mu, ml, md});
        end else begin
          exp_w = exp_q.pop_front();
          if ({mu, ml, md} !== exp_w) begin
            fails++;
            $display("FAIL beat: got %h required %h",
                     {mu, ml, md}, exp_w);
          end
        end
        in_frame = ~ml;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send_frame(input int len, input int base,
                            input bit user, input bit gaps,
                            input bit expect_out,
                            output int ovf_beat);
    ovf_beat = 0;
    for (int i = 0; i < len; i++) begin
      if (gaps && (i % 3) == 2) begin
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_user  = 1'b0;
        @(negedge clk);
      end
      in_valid = 1'b1;
      in_data  = 8'(base + i);
      in_last  = (i == len - 1);
      in_user  = user && (i == len - 1);
      if (expect_out) exp_q.push_back({in_user, in_last, in_data});
      @(negedge clk);
      if (st_ovf && ovf_beat == 0) ovf_beat = i + 1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_user  = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({ma.tvalid, ma.tdata, ma.tlast, ma.tuser, sa.tready,
         ovf_a, bad_a, good_a, mb.tvalid, mb.tdata, sb.tready} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: a_valid=%b a_data=%h a_rdy=%b b_valid=%b required all 0",
               ma.tvalid, ma.tdata, sa.tready, mb.tvalid);
    end
    #2 rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (sa.tready !== 1'b1 || sb.tready !== 1'b1) begin
      fails++;
      $display("FAIL tready_after_reset: a=%b b=%b required 1",
               sa.tready, sb.tready);
    end
    checks++;
    if (ma.tvalid !== 1'b0) begin
      fails++;
      $display("FAIL empty_after_reset: tvalid=%b required 0", ma.tvalid);
    end
  endtask

  task automatic test_basic;
    int o0, g0, ob;
    sel = 1'b0;
    o0 = n_out;
    g0 = n_good;
    send_frame(60, 0, 1'b0, 1'b0, 1'b1, ob);
    @(negedge clk);
    checks++;
    if (ma.tvalid !== 1'b0) begin
      fails++;
      $display("FAIL latency_early: tvalid=%b required 0", ma.tvalid);
    end
    @(negedge clk);
    checks++;
    if (ma.tvalid !== 1'b1) begin
      fails++;
      $display("FAIL latency: tvalid=%b required 1", ma.tvalid);
    end
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL basic_drain: %0d outstanding required 0", exp_q.size());
    end
    checks++;
    if (n_out - o0 != 60 || n_good - g0 != 1) begin
      fails++;
      $display("FAIL basic_counts: beats=%0d good=%0d required 60 1",
               n_out - o0, n_good - g0);
    end
  endtask

  task automatic test_gaps;
    int o0, g0, ob;
    sel = 1'b0;
    o0 = n_out;
    g0 = n_good;
    send_frame(50, 8'h20, 1'b0, 1'b1, 1'b1, ob);
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0 || n_out - o0 != 50 || n_good - g0 != 1) begin
      fails++;
      $display("FAIL gaps: left=%0d beats=%0d good=%0d required 0 50 1",
               exp_q.size(), n_out - o0, n_good - g0);
    end
  endtask

  task automatic test_oversize;
    int o0, v0, g0, ob;
    sel = 1'b0;
    o0 = n_out;
    v0 = n_ovf;
    g0 = n_good;
    send_frame(1600, 0, 1'b0, 1'b0, 1'b0, ob);
    repeat (10) @(negedge clk);
    checks++;
    if (ob != 1523) begin
      fails++;
      $display("FAIL oversize_beat: overflow at %0d required 1523", ob);
    end
    checks++;
    if (n_ovf - v0 != 1 || n_out - o0 != 0 || n_good - g0 != 0) begin
      fails++;
      $display("FAIL oversize_counts: ovf=%0d beats=%0d good=%0d required 1 0 0",
               n_ovf - v0, n_out - o0, n_good - g0);
    end
    send_frame(64, 8'h55, 1'b0, 1'b0, 1'b1, ob);
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0 || n_out - o0 != 64) begin
      fails++;
      $display("FAIL after_oversize: left=%0d beats=%0d required 0 64",
               exp_q.size(), n_out - o0);
    end
  endtask

  task automatic test_overflow;
    int o0, v0, g0, ob;
    logic [7:0] held;
    sel = 1'b1;
    rdy_b = 1'b0;
    o0 = n_out;
    v0 = n_ovf;
    g0 = n_good;
    send_frame(100, 8'h10, 1'b0, 1'b0, 1'b1, ob);
    send_frame(40, 8'hA0, 1'b0, 1'b0, 1'b0, ob);
    repeat (5) @(negedge clk);
    checks++;
    if (n_ovf - v0 != 1 || n_good - g0 != 1) begin
      fails++;
      $display("FAIL overflow_status: ovf=%0d good=%0d required 1 1",
               n_ovf - v0, n_good - g0);
    end
    checks++;
    if (mb.tvalid !== 1'b1 || mb.tdata !== 8'h10) begin
      fails++;
      $display("FAIL stall_head: valid=%b data=%h required 1 10",
               mb.tvalid, mb.tdata);
    end
    held = mb.tdata;
    repeat (5) @(negedge clk);
    checks++;
    if (mb.tvalid !== 1'b1 || mb.tdata !== held || mb.tlast !== 1'b0) begin
      fails++;
      $display("FAIL stall_hold: valid=%b data=%h required 1 %h",
               mb.tvalid, mb.tdata, held);
    end
    rdy_b = 1'b1;
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(negedge clk);
    repeat (20) @(negedge clk);
    checks++;
    if (exp_q.size() != 0 || n_out - o0 != 100) begin
      fails++;
      $display("FAIL overflow_drain: left=%0d beats=%0d required 0 100",
               exp_q.size(), n_out - o0);
    end
  endtask

  task automatic test_bad_frame;
    int o0, b0, g0, ob;
    sel = 1'b0;
    o0 = n_out;
    b0 = n_bad;
    g0 = n_good;
    send_frame(64, 8'h30, 1'b1, 1'b0, 1'b0, ob);
    repeat (20) @(negedge clk);
    checks++;
    if (n_bad - b0 != 1 || n_good - g0 != 0 || n_out - o0 != 0) begin
      fails++;
      $display("FAIL bad_drop: bad=%0d good=%0d beats=%0d required 1 0 0",
               n_bad - b0, n_good - g0, n_out - o0);
    end
    sel = 1'b1;
    o0 = n_out;
    b0 = n_bad;
    g0 = n_good;
    send_frame(64, 8'h70, 1'b1, 1'b0, 1'b1, ob);
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0 || n_out - o0 != 64 ||
        n_bad - b0 != 1 || n_good - g0 != 0) begin
      fails++;
      $display("FAIL bad_forward: left=%0d beats=%0d bad=%0d good=%0d required 0 64 1 0",
               exp_q.size(), n_out - o0, n_bad - b0, n_good - g0);
    end
  endtask

  task automatic test_reset_mid;
    int o0, v0, b0, g0, ob;
    sel = 1'b0;
    rdy_a = 1'b1;
    send_frame(60, 8'h40, 1'b0, 1'b0, 1'b1, ob);
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(8'hC0 + i);
      in_last  = 1'b0;
      in_user  = 1'b0;
      @(negedge clk);
    end
    checks++;
    if (ma.tvalid !== 1'b1) begin
      fails++;
      $display("FAIL pre_reset_busy: tvalid=%b required 1", ma.tvalid);
    end
    #2;
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_frame = 1'b0;
    exp_q.delete();
    #1;
    checks++;
    if ({ma.tvalid, ma.tdata, ma.tlast, ma.tuser, sa.tready,
         ovf_a, bad_a, good_a} !== '0) begin
      fails++;
      $display("FAIL reset_mid_outputs: valid=%b data=%h last=%b rdy=%b required all 0",
               ma.tvalid, ma.tdata, ma.tlast, sa.tready);
    end
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    v0 = n_ovf;
    b0 = n_bad;
    g0 = n_good;
    repeat (5) @(negedge clk);
    checks++;
    if (ma.tvalid !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid_empty: tvalid=%b required 0", ma.tvalid);
    end
    o0 = n_out;
    send_frame(30, 8'h80, 1'b0, 1'b0, 1'b1, ob);
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0 || n_out - o0 != 30 || n_good - g0 != 1 ||
        n_ovf - v0 != 0 || n_bad - b0 != 0) begin
      fails++;
      $display("FAIL reset_mid_next: left=%0d beats=%0d good=%0d ovf=%0d bad=%0d required 0 30 1 0 0",
               exp_q.size(), n_out - o0, n_good - g0,
               n_ovf - v0, n_bad - b0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_oversize();
    test_overflow();
    test_bad_frame();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
